pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game-sequencing FSM for the Pong design. Consumes debounced start, per-frame tick and ball hit/miss pulses from the pixel/physics logic. Drives ball freeze/re-serve, BCD score, remaining lives and a game-over flag for the text/score overlay. Instantiated at top level beside the pixel generator, all on the board clock.

Parameters:
LIVES, 3, balls per game (1..7)
SERVE_FRAMES, 120, frame ticks the ball is held at centre before each serve (1..255)
MISS_FRAMES, 60, frame ticks of freeze after a miss before re-serve or game over (1..255)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high; clears all state
start  in  1  debounced start button, level
frame_tick  in  1  single-cycle pulse once per video frame
hit  in  1  single-cycle pulse, ball struck paddle
miss  in  1  single-cycle pulse, ball passed paddle
ball_reset  out  1  high: pixel logic holds ball at centre
ball_en  out  1  high: ball motion enabled
score_bcd  out  8  two BCD digits, [7:4] tens, [3:0] units
lives  out  3  balls remaining
game_over  out  1  high in OVER state
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, active-high): state=IDLE, score_bcd=8'h00, lives=LIVES, timer=0, ball_reset=1, ball_en=0, game_over=0.
- start edge: registered rising-edge detect; start_rise one cycle after the 0->1 edge is sampled. Held level never retriggers.
- States / transitions (registered; outputs Moore, decoded from state register):
  IDLE: ball_reset=1, ball_en=0. start_rise -> SERVE; timer=0; score=00; lives=LIVES.
  SERVE: ball_reset=1, ball_en=0. timer increments on frame_tick; at frame_tick with timer==SERVE_FRAMES-1 -> PLAY, timer=0.
  PLAY: ball_reset=0, ball_en=1. hit -> score+1. miss -> MISS, lives-1, timer=0.
  MISS: ball_reset=0, ball_en=0 (ball frozen where lost). At frame_tick with timer==MISS_FRAMES-1 -> SERVE if lives!=0, else OVER.
  OVER: ball_reset=1, ball_en=0, game_over=1; score and lives hold. start_rise -> SERVE with score=00, lives=LIVES.
- Score: two-digit BCD, increments units, carries to tens at 9. Saturates at 99 (no wrap).
- hit/miss ignored outside PLAY. hit and miss in the same PLAY cycle: miss wins; no score increment.
- frame_tick coincident with hit/miss: both take effect independently.
- Timer is 8 bits and counts only on frame_tick; no other cycles advance it.
- lives never decrements below 0; the transition to OVER occurs only from MISS.
- state_dbg encoding: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
- Reset asserted mid-game: immediate return to reset values; the edge detector is cleared, so a start held through reset needs a fresh press.

Optional Feature:
SPEEDUP_EN: when defined, adds output speed_lvl [1:0]. Reset and new game set it to 0. It increments (saturating at 3) whenever a PLAY-state hit makes the score units digit roll to 0, i.e. every 10 points. The pixel logic uses it to scale ball velocity. When not defined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pong_pkg: state enum (IDLE..OVER) with 3-bit encoding, TIMER_W=8, LIVES_W=3, SCORE_W=8.
- One sub-module: bcd_counter2. A saturating two-digit BCD counter with clr, inc and async reset, instantiated for score_bcd.
- Timer, FSM and edge detector live in pong_game_ctrl.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, release, hold start=0 for 1000 cycles -> state_dbg=0, ball_reset=1, ball_en=0, score_bcd=00, lives=3.
- Serve timing (SERVE_FRAMES=4): pulse start, then 4 frame_ticks -> state_dbg=1 until the 4th tick, PLAY on the next cycle, ball_en=1.
- Scoring: in PLAY, 12 hit pulses -> score_bcd=8'h12. Force 99 and one more hit -> score stays 8'h99.
- Miss sequence (MISS_FRAMES=2, LIVES=3): three miss cycles, each followed by 2 ticks -> lives 2, 1, 0. After the third, state=OVER with game_over=1 and score held. start -> SERVE, score 00, lives 3.
- Simultaneous events: hit and miss in the same PLAY cycle -> score unchanged, lives-1, state=MISS. Hit during SERVE/MISS -> ignored.
- Async reset mid-PLAY with start held high: outputs return to reset values without waiting for a clock edge. No SERVE entry until start is released and pressed again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and widths for the Pong game sequencing logic.
// Pure declarations: no latency, no flow control.
// Consumers import with pong_pkg::*.
package pong_pkg;

    localparam int TIMER_W = 8;
    localparam int LIVES_W = 3;
    localparam int SCORE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter, saturating at 99, with synchronous clear and async reset.
// Latency: count visible one cycle after inc/clr; clr has priority over inc.
// No backpressure: inc at 99 is silently absorbed.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] bcd
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc && !(tens_q == 4'd9 && units_q == 4'd9)) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign bcd = {tens_q, units_q};

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/miss/over FSM, BCD score, lives (optional SPEEDUP_EN adds speed_lvl).
// Latency: start acts two cycles after its rising edge is sampled; other events act on the next edge.
// No backpressure: pulses outside the state that consumes them are dropped.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 120,
    parameter int MISS_FRAMES  = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic               miss,
    output logic               ball_reset,
    output logic               ball_en,
    output logic [SCORE_W-1:0] score_bcd,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
`ifdef SPEEDUP_EN
    output logic [1:0]         speed_lvl,
`endif
    output logic [2:0]         state_dbg
);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 start_q, start_d;
    logic                 start_rise_q, start_rise_d;
    logic                 ball_reset_q, ball_reset_d;
    logic                 ball_en_q, ball_en_d;
    logic                 game_over_q, game_over_d;
    logic                 score_clr;
    logic                 score_inc;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        lives_d      = lives_q;
        score_clr    = 1'b0;
        score_inc    = 1'b0;
        start_d      = start;
        start_rise_d = start & ~start_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise_q) begin
                    state_d   = ST_SERVE;
                    timer_d   = '0;
                    lives_d   = LIVES_W'(LIVES);
                    score_clr = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (timer_q == TIMER_W'(SERVE_FRAMES - 1)) begin
                        state_d = ST_PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                // A simultaneous miss cancels the hit.
                if (miss) begin
                    state_d = ST_MISS;
                    timer_d = '0;
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            ST_MISS: begin
                if (frame_tick) begin
                    if (timer_q == TIMER_W'(MISS_FRAMES - 1)) begin
                        timer_d = '0;
                        state_d = (lives_q != '0) ? ST_SERVE : ST_OVER;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ball_reset_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_OVER);
        ball_en_d    = (state_d == ST_PLAY);
        game_over_d  = (state_d == ST_OVER);
    end

    // start_q resets high so a button held through reset is not seen as a new press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            lives_q      <= LIVES_W'(LIVES);
            start_q      <= 1'b1;
            start_rise_q <= 1'b0;
            ball_reset_q <= 1'b1;
            ball_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lives_q      <= lives_d;
            start_q      <= start_d;
            start_rise_q <= start_rise_d;
            ball_reset_q <= ball_reset_d;
            ball_en_q    <= ball_en_d;
            game_over_q  <= game_over_d;
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .bcd   (score_bcd)
    );

`ifdef SPEEDUP_EN
    logic [1:0] speed_q, speed_d;

    // Level rises each time a hit rolls the units digit over to 0.
    always_comb begin
        speed_d = speed_q;
        if (score_clr) begin
            speed_d = 2'd0;
        end else if (score_inc && score_bcd[3:0] == 4'd9 && score_bcd[7:4] != 4'd9
                     && speed_q != 2'd3) begin
            speed_d = speed_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_q <= 2'd0;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed_lvl = speed_q;
`endif

    assign ball_reset = ball_reset_q;
    assign ball_en    = ball_en_q;
    assign game_over  = game_over_q;
    assign lives      = lives_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with an integer-level game model checked every cycle.
// Inputs change 2 time units after posedge; outputs are compared on negedge.
// Literal expectations at key points pin the model.
module tb_pong_game_ctrl;

    localparam int LIVES        = 3;
    localparam int SERVE_FRAMES = 4;
    localparam int MISS_FRAMES  = 2;

    logic       clk;
    logic       reset;
    logic       start;
    logic       frame_tick;
    logic       hit;
    logic       miss;
    logic       ball_reset;
    logic       ball_en;
    logic [7:0] score_bcd;
    logic [2:0] lives;
    logic       game_over;
    logic [2:0] state_dbg;
`ifdef SPEEDUP_EN
    logic [1:0] speed_lvl;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pong_game_ctrl #(
        .LIVES        (LIVES),
        .SERVE_FRAMES (SERVE_FRAMES),
        .MISS_FRAMES  (MISS_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .hit        (hit),
        .miss       (miss),
        .ball_reset (ball_reset),
        .ball_en    (ball_en),
        .score_bcd  (score_bcd),
        .lives      (lives),
        .game_over  (game_over),
`ifdef SPEEDUP_EN
        .speed_lvl  (speed_lvl),
`endif
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phase 0..4 = idle, serve, play, miss, over; score kept as a plain integer.
    int m_phase, m_score, m_lives, m_frames;
    bit m_prev_start, m_pressed;

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase      = 0;
            m_score      = 0;
            m_lives      = LIVES;
            m_frames     = 0;
            m_prev_start = 1'b1;
            m_pressed    = 1'b0;
        end else begin
            if ((m_phase == 0 || m_phase == 4) && m_pressed) begin
                m_phase  = 1;
                m_score  = 0;
                m_lives  = LIVES;
                m_frames = 0;
            end else if (m_phase == 1 && frame_tick) begin
                m_frames++;
                if (m_frames == SERVE_FRAMES) begin
                    m_phase  = 2;
                    m_frames = 0;
                end
            end else if (m_phase == 2) begin
                if (miss) begin
                    m_phase  = 3;
                    m_frames = 0;
                    if (m_lives > 0) m_lives--;
                end else if (hit && m_score < 99) begin
                    m_score++;
                end
            end else if (m_phase == 3 && frame_tick) begin
                m_frames++;
                if (m_frames == MISS_FRAMES) begin
                    m_frames = 0;
                    m_phase  = (m_lives > 0) ? 1 : 4;
                end
            end
            m_pressed    = start && !m_prev_start;
            m_prev_start = start;
        end
    end

    always @(negedge clk) begin
        chk("cyc_state", int'(state_dbg), m_phase);
        chk("cyc_ball_reset", int'(ball_reset),
            int'(m_phase == 0 || m_phase == 1 || m_phase == 4));
        chk("cyc_ball_en", int'(ball_en), int'(m_phase == 2));
        chk("cyc_game_over", int'(game_over), int'(m_phase == 4));
        chk("cyc_score", int'(score_bcd), to_bcd(m_score));
        chk("cyc_lives", int'(lives), m_lives);
`ifdef SPEEDUP_EN
        chk("cyc_speed", int'(speed_lvl), (m_score / 10 > 3) ? 3 : m_score / 10);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic hit_n(input int n);
        repeat (n) begin
            hit = 1'b1;
            cyc(1);
            hit = 1'b0;
            cyc(1);
        end
    endtask

    task automatic miss_once();
        miss = 1'b1;
        cyc(1);
        miss = 1'b0;
        cyc(1);
    endtask

    task automatic wait_state(input string name, input int exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(state_dbg) == exp) break;
            cyc(1);
        end
        chk(name, int'(state_dbg), exp);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        #1 reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1000);
        chk("idle_state", int'(state_dbg), 0);
        chk("idle_ball_reset", int'(ball_reset), 1);
        chk("idle_ball_en", int'(ball_en), 0);
        chk("idle_score", int'(score_bcd), 8'h00);
        chk("idle_lives", int'(lives), 3);

        // Serve timing: SERVE holds through 3 ticks, PLAY right after the 4th.
        start = 1'b1;
        wait_state("to_serve", 1, 10);
        start = 1'b0;
        tick_n(3);
        chk("serve_after_3", int'(state_dbg), 1);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        chk("play_after_4", int'(state_dbg), 2);
        chk("play_ball_en", int'(ball_en), 1);
        cyc(1);

        hit_n(12);
        chk("score_12", int'(score_bcd), 8'h12);
`ifdef SPEEDUP_EN
        chk("speed_12", int'(speed_lvl), 1);
`endif
        hit_n(87);
        chk("score_99", int'(score_bcd), 8'h99);
        hit_n(1);
        chk("score_sat", int'(score_bcd), 8'h99);

        // Hit and miss together: miss wins.
        hit  = 1'b1;
        miss = 1'b1;
        cyc(1);
        hit  = 1'b0;
        miss = 1'b0;
        chk("hm_state", int'(state_dbg), 3);
        chk("hm_lives", int'(lives), 2);
        chk("hm_score", int'(score_bcd), 8'h99);
        hit_n(1);
        tick_n(1);
        chk("miss_after_1", int'(state_dbg), 3);
        tick_n(1);
        chk("reserve", int'(state_dbg), 1);
        hit_n(1);
        tick_n(4);
        chk("play2", int'(state_dbg), 2);
        frame_tick = 1'b1;
        hit = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        hit = 1'b0;
        miss_once();
        chk("lives_1", int'(lives), 1);
        tick_n(2);
        tick_n(4);
        miss_once();
        chk("lives_0", int'(lives), 0);
        tick_n(2);
        chk("over_state", int'(state_dbg), 4);
        chk("over_flag", int'(game_over), 1);
        chk("over_score", int'(score_bcd), 8'h99);
        chk("over_lives", int'(lives), 0);
        cyc(5);

        // New game from OVER, start then held high.
        start = 1'b1;
        wait_state("over_to_serve", 1, 10);
        chk("new_score", int'(score_bcd), 8'h00);
        chk("new_lives", int'(lives), 3);
        tick_n(4);
        hit_n(3);
        chk("new_score3", int'(score_bcd), 8'h03);

        // Async reset between clock edges.
        #1 reset = 1'b1;
        #1;
        chk("arst_state", int'(state_dbg), 0);
        chk("arst_ball_reset", int'(ball_reset), 1);
        chk("arst_ball_en", int'(ball_en), 0);
        chk("arst_score", int'(score_bcd), 8'h00);
        chk("arst_lives", int'(lives), 3);
        cyc(2);
        reset = 1'b0;
        cyc(20);
        chk("held_no_serve", int'(state_dbg), 0);
        start = 1'b0;
        cyc(2);
        start = 1'b1;
        wait_state("repress_serve", 1, 10);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
